// File: rtl/cog_div_scheduler.sv
// cog_div_scheduler: one serial restoring divider shared by NUM_CH
// centre-of-gravity channels. Each channel has a one-entry holding buffer.
// A round-robin arbiter picks the next pending channel. The block computes
// point = (start_point << FRAC_BITS) + (sum_mult << FRAC_BITS) / sum_I,
// saturates it to SP_W+FRAC_BITS bits, and hands it off over valid/ready.
// Optional macro COG_ROUND_EN: computes one extra quotient bit and uses it
// to round half up instead of truncating. This adds one cycle of latency.
module cog_div_scheduler #(
  parameter  int NUM_CH    = 4,
  parameter  int FRAC_BITS = 4,
  parameter  int NUM_W     = 30,
  parameter  int DEN_W     = 23,
  parameter  int SP_W      = 11,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int OUT_W     = SP_W + FRAC_BITS
) (
  input  logic                     i_sys_clk,
  input  logic                     i_sys_reset,
  input  logic [NUM_CH*NUM_W-1:0]  i_sum_of_I_mult_coord,
  input  logic [NUM_CH*DEN_W-1:0]  i_sum_of_I,
  input  logic [NUM_CH*SP_W-1:0]   i_start_point,
  input  logic [NUM_CH-1:0]        i_point_valid,
  output logic [OUT_W-1:0]         o_point,
  output logic [CH_W-1:0]          o_point_ch,
  output logic                     o_point_valid,
  input  logic                     i_point_ready,
  output logic                     o_div_zero,
  output logic [NUM_CH-1:0]        o_overflow,
  output logic                     o_busy
);

  localparam int ITER   = NUM_W + FRAC_BITS;
`ifdef COG_ROUND_EN
  localparam int ITER_N = ITER + 1;
`else
  localparam int ITER_N = ITER;
`endif
  localparam int SUM_W  = ((ITER_N > OUT_W) ? ITER_N : OUT_W) + 1;
  localparam int CNT_W  = $clog2(ITER_N + 1);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_ADD, S_OUT} state_t;

  state_t               state;
  logic [NUM_CH-1:0]    pend;
  logic [CH_W-1:0]      rr_ptr;
  logic [CH_W-1:0]      gnt;
  logic [CH_W-1:0]      cur_ch;
  logic                 grant_en;
  logic [NUM_CH-1:0]    cap;
  logic [NUM_CH-1:0]    ovf_nxt;
  logic [CNT_W-1:0]     cnt;
  logic                 dz;

  logic [NUM_W-1:0]     hold_num [NUM_CH];
  logic [DEN_W-1:0]     hold_den [NUM_CH];
  logic [SP_W-1:0]      hold_sp  [NUM_CH];

  // The dividend shifts out of the top while quotient bits shift in at the bottom.
  logic [ITER_N-1:0]    dvd;
  logic [DEN_W:0]       rem;
  logic [DEN_W:0]       rem_sh;
  logic [DEN_W:0]       rem_nxt;
  logic                 qbit;
  logic [DEN_W-1:0]     dnm;
  logic [SP_W-1:0]      spv;

  function automatic logic [SUM_W-1:0] round_q(input logic [ITER_N-1:0] q);
`ifdef COG_ROUND_EN
    return SUM_W'(q >> 1) + SUM_W'(q[0]);
`else
    return SUM_W'(q);
`endif
  endfunction

  function automatic logic [OUT_W-1:0] sat(input logic [SUM_W-1:0] s);
    if (s > SUM_W'({OUT_W{1'b1}}))
      return '1;
    else
      return s[OUT_W-1:0];
  endfunction

  assign o_busy = (state != S_IDLE);

  // Round-robin search that starts one past the last granted channel.
  always_comb begin
    gnt = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      if (pend[(int'(rr_ptr) + i) % NUM_CH])
        gnt = CH_W'((int'(rr_ptr) + i) % NUM_CH);
    end
  end

  // Capture and overflow decisions. A channel being granted this cycle frees its slot.
  always_comb begin
    grant_en = (state == S_IDLE) && (|pend);
    cap      = '0;
    ovf_nxt  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      cap[c]     = i_point_valid[c] && (!pend[c] || (grant_en && gnt == CH_W'(c)));
      ovf_nxt[c] = i_point_valid[c] && pend[c] && !(grant_en && gnt == CH_W'(c));
    end
  end

  // One restoring-division step: shift in the next dividend bit and try to subtract.
  always_comb begin
    rem_sh  = {rem[DEN_W-1:0], dvd[ITER_N-1]};
    qbit    = (rem_sh >= {1'b0, dnm});
    rem_nxt = qbit ? (rem_sh - {1'b0, dnm}) : rem_sh;
  end

  // Per-channel holding registers for the sums.
  always_ff @(posedge i_sys_clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (cap[c]) begin
        hold_num[c] <= i_sum_of_I_mult_coord[c*NUM_W +: NUM_W];
        hold_den[c] <= i_sum_of_I[c*DEN_W +: DEN_W];
        hold_sp[c]  <= i_start_point[c*SP_W +: SP_W];
      end
    end
  end

  // Divider datapath: load operands on grant, then iterate while in DIV.
  always_ff @(posedge i_sys_clk) begin
    if (grant_en) begin
      dvd <= ITER_N'(hold_num[gnt]) << (ITER_N - NUM_W);
      rem <= '0;
      dnm <= hold_den[gnt];
      spv <= hold_sp[gnt];
    end else if (state == S_DIV) begin
      dvd <= {dvd[ITER_N-2:0], qbit};
      rem <= rem_nxt;
    end
  end

  // Control: pending flags, arbitration pointer, divider FSM and registered outputs.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_reset) begin
      state         <= S_IDLE;
      pend          <= '0;
      rr_ptr        <= CH_W'(NUM_CH - 1);
      cur_ch        <= '0;
      cnt           <= '0;
      dz            <= 1'b0;
      o_point       <= '0;
      o_point_ch    <= '0;
      o_point_valid <= 1'b0;
      o_div_zero    <= 1'b0;
      o_overflow    <= '0;
    end else begin
      o_overflow <= ovf_nxt;
      for (int c = 0; c < NUM_CH; c++) begin
        if (cap[c])
          pend[c] <= 1'b1;
        else if (grant_en && gnt == CH_W'(c))
          pend[c] <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (|pend) begin
            rr_ptr <= gnt;
            cur_ch <= gnt;
            cnt    <= '0;
            dz     <= (hold_den[gnt] == '0);
            state  <= (hold_den[gnt] == '0) ? S_ADD : S_DIV;
          end
        end
        S_DIV: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(ITER_N - 1))
            state <= S_ADD;
        end
        S_ADD: begin
          o_point       <= sat(SUM_W'({spv, {FRAC_BITS{1'b0}}}) + (dz ? '0 : round_q(dvd)));
          o_point_ch    <= cur_ch;
          o_div_zero    <= dz;
          o_point_valid <= 1'b1;
          state         <= S_OUT;
        end
        S_OUT: begin
          if (i_point_ready) begin
            o_point_valid <= 1'b0;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cog_div_scheduler.sv
// Directed bench for cog_div_scheduler with default parameters.
module tb_cog_div_scheduler;
  localparam int NUM_CH = 4, NUM_W = 30, DEN_W = 23, SP_W = 11, FRAC_BITS = 4;
`ifdef COG_ROUND_EN
  localparam int LAT = 38;
  localparam int RND = 11;
`else
  localparam int LAT = 37;
  localparam int RND = 10;
`endif

  logic                       clk = 1'b0;
  logic                       rst;
  logic [NUM_CH*NUM_W-1:0]    sm;
  logic [NUM_CH*DEN_W-1:0]    si;
  logic [NUM_CH*SP_W-1:0]     sp;
  logic [NUM_CH-1:0]          vld;
  logic [SP_W+FRAC_BITS-1:0]  point;
  logic [1:0]                 point_ch;
  logic                       point_valid;
  logic                       ready;
  logic                       div_zero;
  logic [NUM_CH-1:0]          ovf;
  logic                       busy;

  int checks = 0;
  int errors = 0;
  int n;
  int cnt;

  cog_div_scheduler dut (
    .i_sys_clk             (clk),
    .i_sys_reset           (rst),
    .i_sum_of_I_mult_coord (sm),
    .i_sum_of_I            (si),
    .i_start_point         (sp),
    .i_point_valid         (vld),
    .o_point               (point),
    .o_point_ch            (point_ch),
    .o_point_valid         (point_valid),
    .i_point_ready         (ready),
    .o_div_zero            (div_zero),
    .o_overflow            (ovf),
    .o_busy                (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load(input int c, input int num, input int den, input int s);
    sm[c*NUM_W +: NUM_W] = NUM_W'(num);
    si[c*DEN_W +: DEN_W] = DEN_W'(den);
    sp[c*SP_W +: SP_W]   = SP_W'(s);
  endtask

  task automatic pulse(input logic [NUM_CH-1:0] m);
    vld = m;
    tick();
    vld = '0;
  endtask

  // Returns the number of edges since the pulse edge until valid is seen (bounded).
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!point_valid && lat < 300) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    rst = 1'b1; ready = 1'b1; vld = '0; sm = '0; si = '0; sp = '0;
    tick(); tick();
    chk("rst_valid", 64'(point_valid), 0);
    chk("rst_point", 64'(point), 0);
    chk("rst_ch", 64'(point_ch), 0);
    chk("rst_dz", 64'(div_zero), 0);
    chk("rst_ovf", 64'(ovf), 0);
    chk("rst_busy", 64'(busy), 0);
    rst = 1'b0;
    tick();

    // Single result on channel 0
    load(0, 600, 300, 100);
    pulse(4'b0001);
    wait_valid(n);
    chk("single_lat", 64'(n), 64'(LAT));
    chk("single_point", 64'(point), 1632);
    chk("single_ch", 64'(point_ch), 0);
    chk("single_dz", 64'(div_zero), 0);
    tick();
    chk("single_drop", 64'(point_valid), 0);

    // Round-robin: fresh reset, ch1 and ch3 together
    rst = 1'b1; tick(); rst = 1'b0; tick();
    load(1, 30, 3, 1);
    load(3, 48, 4, 2);
    pulse(4'b1010);
    wait_valid(n);
    chk("rr1_ch", 64'(point_ch), 1);
    chk("rr1_point", 64'(point), 176);
    tick();
    wait_valid(n);
    chk("rr2_ch", 64'(point_ch), 3);
    chk("rr2_point", 64'(point), 224);
    tick();
    load(0, 10, 5, 7);
    pulse(4'b1001);
    wait_valid(n);
    chk("rr3_ch", 64'(point_ch), 0);
    chk("rr3_point", 64'(point), 144);
    tick();
    wait_valid(n);
    chk("rr4_ch", 64'(point_ch), 3);
    chk("rr4_point", 64'(point), 224);
    tick();

    // Divide by zero on channel 2
    load(2, 123, 0, 5);
    pulse(4'b0100);
    wait_valid(n);
    chk("dz_lat", 64'(n), 3);
    chk("dz_point", 64'(point), 80);
    chk("dz_flag", 64'(div_zero), 1);
    chk("dz_ch", 64'(point_ch), 2);
    tick();

    // Overflow on channel 0 while the divider works on channel 1
    load(1, 100, 10, 0);
    pulse(4'b0010);
    tick();
    chk("ovf_busy", 64'(busy), 1);
    load(0, 64, 8, 3);
    pulse(4'b0001);
    chk("ovf_first", 64'(ovf), 0);
    tick(); tick(); tick(); tick();
    load(0, 99, 9, 9);
    pulse(4'b0001);
    chk("ovf_pulse", 64'(ovf), 1);
    tick();
    chk("ovf_clear", 64'(ovf), 0);
    wait_valid(n);
    chk("ovf_ch1", 64'(point_ch), 1);
    chk("ovf_pt1", 64'(point), 160);
    tick();
    wait_valid(n);
    chk("ovf_ch0", 64'(point_ch), 0);
    chk("ovf_pt0", 64'(point), 176);
    tick();

    // Backpressure: hold ready low for 20 cycles
    ready = 1'b0;
    load(3, 16, 2, 1);
    pulse(4'b1000);
    wait_valid(n);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (point_valid !== 1'b1 || point !== 15'd144 || point_ch !== 2'd3) cnt++;
      tick();
    end
    chk("bp_stable", 64'(cnt), 0);
    chk("bp_point", 64'(point), 144);
    ready = 1'b1;
    tick();
    chk("bp_drop", 64'(point_valid), 0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (point_valid) cnt++;
      tick();
    end
    chk("bp_single", 64'(cnt), 0);

    // Saturation
    load(2, 300, 1, 2047);
    pulse(4'b0100);
    wait_valid(n);
    chk("sat_point", 64'(point), 32767);
    tick();

    // Rounding/truncation of 2/3
    load(1, 2, 3, 0);
    pulse(4'b0010);
    wait_valid(n);
    chk("rnd_lat", 64'(n), 64'(LAT));
    chk("rnd_point", 64'(point), 64'(RND));
    tick();

    // Reset in the middle of a divide
    load(0, 600, 300, 100);
    pulse(4'b0001);
    for (int i = 0; i < 10; i++) tick();
    chk("mid_busy", 64'(busy), 1);
    rst = 1'b1;
    tick();
    chk("mid_valid", 64'(point_valid), 0);
    chk("mid_point", 64'(point), 0);
    chk("mid_ch", 64'(point_ch), 0);
    chk("mid_dz", 64'(div_zero), 0);
    chk("mid_busy0", 64'(busy), 0);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (point_valid || busy) cnt++;
      tick();
    end
    chk("mid_none", 64'(cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
